// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: bus widths, the NOP encoding and the fetch FSM states.
package fetch_stage_pkg;

  localparam int INST_ADDR_LENGTH = 16;
  localparam int INST_BUS_LENGTH  = 16;

  localparam logic [15:0] NOP_INST = 16'h0000;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a fetched word, hold it, clear its valid bit,
// or squash it to a NOP.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_LENGTH,
  parameter int INST_W = INST_BUS_LENGTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              load_valid,
  input  logic              squash,
  input  logic              clear_valid,
  input  logic [INST_W-1:0] inst_d,
  input  logic [ADDR_W-1:0] pc_d,
  output logic [INST_W-1:0] inst_q,
  output logic [ADDR_W-1:0] pc_q,
  output logic              valid_q
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs as they were before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q  <= INST_W'(NOP_INST);
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (squash) begin
      // The PC field keeps its old value; only the word and its valid bit are killed.
      inst_q  <= INST_W'(NOP_INST);
      valid_q <= 1'b0;
    end else if (load) begin
      inst_q  <= inst_d;
      pc_q    <= pc_d;
      valid_q <= load_valid;
    end else if (clear_valid) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC and the RUN/HALT FSM, addresses the ROM
// and feeds the IF/ID register with stall, flush and redirect handling.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int ADDR_W     = INST_ADDR_LENGTH,
  parameter int INST_W     = INST_BUS_LENGTH,
  parameter int IMEM_DEPTH = 38
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic [ADDR_W-1:0] pc_o,
  input  logic [INST_W-1:0] inst_i,
  output logic [INST_W-1:0] if_id_inst_o,
  output logic [ADDR_W-1:0] if_id_pc_o,
  output logic              if_id_valid_o,
  output logic              halted_o
);

  localparam logic [ADDR_W-1:0] DEPTH = ADDR_W'(IMEM_DEPTH);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic              in_program;

  logic load, load_valid, squash, clear_valid;

  assign in_program = (pc < DEPTH);
  assign pc_o       = pc;
  assign halted_o   = (state == FETCH_HALT);

  // NOTE: every signal driven here gets a default first, so no path through
  // the branches leaves it unassigned and no latch is inferred.
  always_comb begin
    load        = 1'b0;
    load_valid  = 1'b0;
    squash      = 1'b0;
    clear_valid = 1'b0;
    if (state == FETCH_RUN) begin
      if (redirect_i) begin
        squash = 1'b1;
      end else if (stall_i) begin
        clear_valid = flush_i;
      end else if (in_program) begin
        load       = 1'b1;
        load_valid = !flush_i;
      end else begin
        clear_valid = 1'b1;
      end
    end
  end

  // In HALT the IF/ID word is already invalid, so stall/flush have nothing to do.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= '0;
      state <= FETCH_RUN;
    end else begin
      unique case (state)
        FETCH_RUN: begin
          if (redirect_i) begin
            pc <= redirect_pc_i;
          end else if (!stall_i) begin
            if (in_program) pc <= pc + ADDR_W'(1);
            else            state <= FETCH_HALT;
          end
        end
        FETCH_HALT: begin
          if (redirect_i) begin
            pc    <= redirect_pc_i;
            state <= FETCH_RUN;
          end
        end
        default: state <= FETCH_RUN;
      endcase
    end
  end

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .INST_W (INST_W)
  ) u_if_id_reg (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_valid  (load_valid),
    .squash      (squash),
    .clear_valid (clear_valid),
    .inst_d      (inst_i),
    .pc_d        (pc),
    .inst_q      (if_id_inst_o),
    .pc_q        (if_id_pc_o),
    .valid_q     (if_id_valid_o)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural 38-word ROM on pc_o/inst_i.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, flush_i, redirect_i;
  logic [15:0] redirect_pc_i;
  logic [15:0] pc_o;
  logic [15:0] inst_i;
  logic [15:0] if_id_inst_o;
  logic [15:0] if_id_pc_o;
  logic        if_id_valid_o;
  logic        halted_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Program store: word 0 is 16'h8800, the rest a recognisable pattern; out of program reads junk.
  function automatic logic [15:0] rom_word(input logic [15:0] a);
    if (a == 16'd0)       return 16'h8800;
    else if (a < 16'd38)  return 16'h4000 + (a << 8) + a;
    else                  return 16'hDEAD;
  endfunction

  assign inst_i = rom_word(pc_o);

  fetch_stage #(
    .ADDR_W     (16),
    .INST_W     (16),
    .IMEM_DEPTH (38)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .pc_o          (pc_o),
    .inst_i        (inst_i),
    .if_id_inst_o  (if_id_inst_o),
    .if_id_pc_o    (if_id_pc_o),
    .if_id_valid_o (if_id_valid_o),
    .halted_o      (halted_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One rising edge, then settle away from it before checking or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [15:0] pc, input logic valid);
    check({tag, ".if_id_pc"}, 32'(if_id_pc_o), 32'(pc));
    check({tag, ".valid"}, 32'(if_id_valid_o), 32'(valid));
    if (valid) check({tag, ".inst"}, 32'(if_id_inst_o), 32'(rom_word(pc)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    step();
    check("rst.pc_o", 32'(pc_o), 32'd0);
    check("rst.inst", 32'(if_id_inst_o), 32'h0000);
    check("rst.if_id_pc", 32'(if_id_pc_o), 32'd0);
    check("rst.valid", 32'(if_id_valid_o), 32'd0);
    check("rst.halted", 32'(halted_o), 32'd0);

    rst = 1'b0;
    step();
    check("run0.inst", 32'(if_id_inst_o), 32'h8800);
    check_ifid("run0", 16'd0, 1'b1);
    check("run0.pc_o", 32'(pc_o), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      step();
      check_ifid("run", 16'(k), 1'b1);
    end
    check("pre_stall.pc_o", 32'(pc_o), 32'd5);

    stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall.pc_o", 32'(pc_o), 32'd5);
      check_ifid("stall", 16'd4, 1'b1);
    end
    stall_i = 1'b0;
    step();
    check_ifid("unstall", 16'd5, 1'b1);
    check("unstall.pc_o", 32'(pc_o), 32'd6);

    for (int k = 6; k <= 22; k++) begin
      step();
      check_ifid("run2", 16'(k), 1'b1);
    end
    check("pre_redir.pc_o", 32'(pc_o), 32'd23);

    redirect_i = 1'b1; redirect_pc_i = 16'd24;
    step();
    check("redir.valid", 32'(if_id_valid_o), 32'd0);
    check("redir.pc_o", 32'(pc_o), 32'd24);
    check("redir.inst_nop", 32'(if_id_inst_o), 32'h0000);
    redirect_i = 1'b0;
    step();
    check_ifid("redir_tgt", 16'd24, 1'b1);
    check("redir_tgt.pc_o", 32'(pc_o), 32'd25);

    flush_i = 1'b1;
    step();
    check_ifid("flush", 16'd25, 1'b0);
    check("flush.inst", 32'(if_id_inst_o), 32'(rom_word(16'd25)));
    check("flush.pc_o", 32'(pc_o), 32'd26);
    flush_i = 1'b0;
    step();
    check_ifid("post_flush", 16'd26, 1'b1);

    stall_i = 1'b1; flush_i = 1'b1;
    step();
    check_ifid("stall_flush", 16'd26, 1'b0);
    check("stall_flush.inst", 32'(if_id_inst_o), 32'(rom_word(16'd26)));
    check("stall_flush.pc_o", 32'(pc_o), 32'd27);

    redirect_i = 1'b1; redirect_pc_i = 16'd35;
    step();
    check("all3.pc_o", 32'(pc_o), 32'd35);
    check("all3.valid", 32'(if_id_valid_o), 32'd0);
    stall_i = 1'b0; flush_i = 1'b0; redirect_i = 1'b0;
    for (int k = 35; k <= 37; k++) begin
      step();
      check_ifid("tail", 16'(k), 1'b1);
      check("tail.halted", 32'(halted_o), 32'd0);
    end
    check("end.pc_o", 32'(pc_o), 32'd38);

    step();
    check("halt.halted", 32'(halted_o), 32'd1);
    check("halt.valid", 32'(if_id_valid_o), 32'd0);
    check("halt.pc_o", 32'(pc_o), 32'd38);
    for (int k = 0; k < 10; k++) begin
      stall_i = (k == 3); flush_i = (k == 5);
      step();
      check("halt_hold.pc_o", 32'(pc_o), 32'd38);
      check("halt_hold.halted", 32'(halted_o), 32'd1);
      check("halt_hold.valid", 32'(if_id_valid_o), 32'd0);
    end
    stall_i = 1'b0; flush_i = 1'b0;

    redirect_i = 1'b1; redirect_pc_i = 16'd0;
    step();
    check("unhalt.halted", 32'(halted_o), 32'd0);
    check("unhalt.pc_o", 32'(pc_o), 32'd0);
    check("unhalt.valid", 32'(if_id_valid_o), 32'd0);
    redirect_i = 1'b0;
    step();
    check_ifid("restart", 16'd0, 1'b1);
    check("restart.pc_o", 32'(pc_o), 32'd1);

    for (int k = 1; k <= 16; k++) step();
    check("pre_rst.pc_o", 32'(pc_o), 32'd17);
    stall_i = 1'b1;
    step();
    check("pre_rst_stall.pc_o", 32'(pc_o), 32'd17);
    rst = 1'b1;
    step();
    check("rst2.pc_o", 32'(pc_o), 32'd0);
    check("rst2.inst", 32'(if_id_inst_o), 32'h0000);
    check("rst2.if_id_pc", 32'(if_id_pc_o), 32'd0);
    check("rst2.valid", 32'(if_id_valid_o), 32'd0);
    check("rst2.halted", 32'(halted_o), 32'd0);
    rst = 1'b0; stall_i = 1'b0;
    step();
    check_ifid("rst2_run", 16'd0, 1'b1);
    check("rst2_run.pc_o", 32'(pc_o), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
